nop_seq_multiplier: RTL and testbench
=====================================

Name: nop_seq_multiplier

Overview:
Sequential, parametrised N-operand multiplier: successor to the fixed 4x32 multiplier, computing the full-precision product of NUM_OPS operands of WIDTH bits each. Adds signed/unsigned mode and a zero-operand early exit. Uses radix-2 shift-add, one multiplier bit per cycle, and keeps the Valid/Done/Acknowledged/Idle handshake of the existing multiplier family. Sits behind a bus-side controller that loads operands and collects the result.

Parameters:
WIDTH, 32, bits per operand (4..64)
NUM_OPS, 4, operand count (2..8)
RESULT_W, WIDTH*NUM_OPS, localparam, result width; not overridable

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  synchronous, active-low reset (sampled on Clock rising edge; 0 = reset)
iValid_Data  in  1  operands valid; sampled only in IDLE
iData  in  NUM_OPS*WIDTH  packed operands; operand k at [k*WIDTH +: WIDTH]
iSigned  in  1  1 = two's-complement operands; captured with iData
iAcknoledged  in  1  consumer acknowledge of oDone
oDone  out  1  result valid, held until acknowledged
oIdle  out  1  ready to accept operands
oResult  out  RESULT_W  product; two's complement when captured iSigned=1

Behaviour:
- All outputs registered. Reset (Reset=0 at an edge), including mid-operation: state=IDLE, oIdle=1, oDone=0, oResult=0. Any in-flight computation is discarded.
- States: IDLE, MUL, FIX, DONE, ACK_WAIT.
- IDLE, edge E0 with iValid_Data=1:
  - Capture the magnitude of each operand. If iSigned=1 and the MSB is 1, magnitude = two's-complement negation; -2^(WIDTH-1) maps to 2^(WIDTH-1), which is valid unsigned.
  - neg_flag = XOR of the operand sign bits when iSigned=1; otherwise 0.
  - acc = magnitude of operand 0.
  - oIdle drops after E0.
  - If any magnitude is 0: acc=0, neg_flag=0, go to FIX. Otherwise go to MUL.
  - iValid_Data=0 in IDLE: no action.
- MUL: one pass per operand k=1..NUM_OPS-1, WIDTH cycles per pass, bit i=0..WIDTH-1.
  - Each cycle: if bit i of operand k is 1, then partial += acc << i, computed modulo 2^RESULT_W.
  - At the end of a pass, acc = partial and partial is cleared.
  - MUL occupies exactly (NUM_OPS-1)*WIDTH edges, then goes to FIX.
  - The exact product of magnitudes is < 2^(NUM_OPS*WIDTH), so no overflow is possible.
- FIX (1 cycle): oResult = neg_flag ? -acc : acc. Go to DONE; oDone=1.
- Latency: oDone is high after edge E0 + (NUM_OPS-1)*WIDTH + 1 (97 cycles at defaults). Zero shortcut: after edge E0+1.
- DONE: oDone held high and oResult stable.
  - Edge with iAcknoledged=1: oDone=0, go to ACK_WAIT.
  - If iAcknoledged is already 1 on entry, exit on the next edge.
- ACK_WAIT: on an edge with iAcknoledged=0, go to IDLE; oIdle=1.
- iValid_Data is ignored outside IDLE. iData and iSigned changing mid-operation have no effect.
- oResult changes only on FIX exit and on reset. It retains the last result through IDLE and the next computation.
- Simultaneous reset and any other event: reset wins.

Decomposition:
- Package nop_mult_pkg:
  - state enum (IDLE, MUL, FIX, DONE, ACK_WAIT)
  - function abs_ext(value, signed_mode) returning the WIDTH-bit magnitude
  - localparam derivation RESULT_W
  - bit/operand counter width function: clog2 of WIDTH and of NUM_OPS
- One natural sub-module, nop_mult_step:
  - combinational conditional shift-add of acc << i into partial, RESULT_W wide
  - separate so it can be swapped for a radix-4 step later
- Controller, counters and registers live in the top module.

Test Plan:
1. Defaults, iSigned=0, operands 1,2,3,4, Valid pulse, ack 5 cycles after oDone -> oResult=24, oDone after edge E0+97, oIdle=1 after iAcknoledged returns to 0.
2. iSigned=1, operands -1,2,3,4 -> oResult=0xFFFF...FFE8 (-24, 128 bit). Operands -1,2,-3,4 -> 24. Operands 0x80000000,1,1,1 -> 0xFFFF...FF80000000.
3. iSigned=0, all operands 0xFFFFFFFF -> oResult=(2^32-1)^4 exactly, 97-cycle latency.
4. Operands 0,5,6,7 (also with iSigned=1, operands -3,0,...) -> oResult=0, oDone after edge E0+1. Latency differs from scenario 1.
5. WIDTH=8, NUM_OPS=3, operands 255,255,255 -> oResult=0xFD02FF, oDone after edge E0+17.
6. Protocol and reset:
   - Valid pulses with new operands during MUL and DONE -> ignored, result unchanged.
   - Reset=0 mid-MUL -> next edge oIdle=1, oDone=0, oResult=0; the following operation is correct.
   - iAcknoledged held high before oDone -> single-cycle oDone, then ACK_WAIT until ack falls.

Source files
------------

// File: rtl/nop_seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nop_mult_pkg
// Purpose  : Shared types and helpers for the N-operand sequential multiplier:
//            controller state encoding, signed-magnitude extraction and
//            derived width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package nop_mult_pkg;

  // Widest operand the magnitude helper supports
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_FIX      = 3'd2,
    S_DONE     = 3'd3,
    S_ACK_WAIT = 3'd4
  } state_t;

  // Full-precision product width of num_ops operands of width bits
  function automatic int result_w(input int width, input int num_ops);
    return width * num_ops;
  endfunction

  // Counter width able to index 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Magnitude of a width-bit operand held in the low bits of value.
  // The most negative value maps to 2^(width-1), still representable unsigned.
  function automatic logic [MAX_W-1:0] abs_ext(input logic [MAX_W-1:0] value,
                                                input int unsigned      width,
                                                input logic             signed_mode);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    if (signed_mode && value[6'(width - 1)])
      return (~value + 1'b1) & mask;
    return value & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nop_seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : nop_seq_multiplier_if
// Purpose  : Operand/result handshake bundle between the bus-side controller
//            (master) and the sequential multiplier (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface nop_seq_multiplier_if
  import nop_mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4
);
  localparam int RESULT_W = result_w(WIDTH, NUM_OPS);

  logic                       iValid_Data;
  logic [NUM_OPS*WIDTH-1:0]   iData;
  logic                       iSigned;
  logic                       iAcknoledged;
  logic                       oDone;
  logic                       oIdle;
  logic [RESULT_W-1:0]        oResult;

  modport master (
    output iValid_Data, iData, iSigned, iAcknoledged,
    input  oDone, oIdle, oResult
  );

  modport slave (
    input  iValid_Data, iData, iSigned, iAcknoledged,
    output oDone, oIdle, oResult
  );
endinterface
`default_nettype wire

// File: rtl/nop_seq_multiplier_step.sv
`default_nettype none
// ============================================================================
// Module   : nop_mult_step
// Purpose  : One radix-2 shift-add step: partial += acc << shift when the
//            current multiplier bit is set, wrapping at the result width.
// Revision : 1.0 - initial release
// ============================================================================
module nop_mult_step #(
  parameter int RESULT_W = 128,
  parameter int SHIFT_W  = 5
) (
  input  wire logic [RESULT_W-1:0] i_acc,
  input  wire logic [RESULT_W-1:0] i_partial,
  input  wire logic                i_bit,
  input  wire logic [SHIFT_W-1:0]  i_shift,
  output      logic [RESULT_W-1:0] o_partial
);

  logic [RESULT_W-1:0] w_shifted;

  assign w_shifted = i_acc << i_shift;
  assign o_partial = i_bit ? (i_partial + w_shifted) : i_partial;

endmodule
`default_nettype wire

// File: rtl/nop_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : nop_seq_multiplier
// Purpose  : Sequential N-operand multiplier, radix-2 shift-add, with signed
//            mode, zero-operand early exit and Valid/Done/Ack/Idle handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nop_seq_multiplier
  import nop_mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4
) (
  input wire logic             Clock,
  input wire logic             Reset,
  nop_seq_multiplier_if.slave  bus
);

  localparam int RESULT_W = result_w(WIDTH, NUM_OPS);
  localparam int BIT_W    = cnt_w(WIDTH);
  localparam int OP_W     = cnt_w(NUM_OPS);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [OP_W-1:0]  LAST_OP  = OP_W'(NUM_OPS - 1);

  state_t                           r_state;
  logic [RESULT_W-1:0]              r_acc;
  logic [RESULT_W-1:0]              r_partial;
  logic [RESULT_W-1:0]              r_result;
  // Operand 0 seeds the accumulator, so only multipliers 1..NUM_OPS-1 are kept
  logic [NUM_OPS-1:1][WIDTH-1:0]    r_ops;
  logic                             r_neg;
  logic                             r_done;
  logic                             r_idle;
  logic [BIT_W-1:0]                 r_bit;
  logic [OP_W-1:0]                  r_op;

  logic [NUM_OPS-1:0][WIDTH-1:0]    w_mag;
  logic [NUM_OPS-1:0]               w_sign;
  logic [NUM_OPS-1:0]               w_zero;
  logic                             w_neg;
  logic                             w_any_zero;
  logic                             w_cur_bit;
  logic [RESULT_W-1:0]              w_sum;

  // Per-operand magnitude, sign and zero detection on the incoming bus
  generate
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_mag
      assign w_mag[k]  = WIDTH'(abs_ext(MAX_W'(bus.iData[k*WIDTH +: WIDTH]),
                                        WIDTH, bus.iSigned));
      assign w_sign[k] = bus.iData[k*WIDTH + WIDTH - 1];
      assign w_zero[k] = (w_mag[k] == '0);
    end
  endgenerate

  assign w_neg      = bus.iSigned & (^w_sign);
  assign w_any_zero = |w_zero;
  assign w_cur_bit  = r_ops[r_op][r_bit];

  nop_mult_step #(
    .RESULT_W (RESULT_W),
    .SHIFT_W  (BIT_W)
  ) u_step (
    .i_acc     (r_acc),
    .i_partial (r_partial),
    .i_bit     (w_cur_bit),
    .i_shift   (r_bit),
    .o_partial (w_sum)
  );

  // Controller: capture, shift-add passes, sign fix-up and handshake
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_idle    <= 1'b1;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_acc     <= '0;
      r_partial <= '0;
      r_ops     <= '0;
      r_neg     <= 1'b0;
      r_bit     <= '0;
      r_op      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.iValid_Data) begin
            r_idle    <= 1'b0;
            r_partial <= '0;
            r_bit     <= '0;
            r_op      <= OP_W'(1);
            r_ops     <= w_mag[NUM_OPS-1:1];
            if (w_any_zero) begin
              r_acc   <= '0;
              r_neg   <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_acc   <= RESULT_W'(w_mag[0]);
              r_neg   <= w_neg;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_bit == LAST_BIT) begin
            r_acc     <= w_sum;
            r_partial <= '0;
            r_bit     <= '0;
            if (r_op == LAST_OP) r_state <= S_FIX;
            else                 r_op    <= r_op + OP_W'(1);
          end else begin
            r_partial <= w_sum;
            r_bit     <= r_bit + BIT_W'(1);
          end
        end
        S_FIX: begin
          r_result <= r_neg ? (~r_acc + 1'b1) : r_acc;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (bus.iAcknoledged) begin
            r_done  <= 1'b0;
            r_state <= S_ACK_WAIT;
          end
        end
        S_ACK_WAIT: begin
          if (!bus.iAcknoledged) begin
            r_idle  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oDone   = r_done;
  assign bus.oIdle   = r_idle;
  assign bus.oResult = r_result;

endmodule
`default_nettype wire

// File: tb/tb_nop_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_nop_seq_multiplier
// Purpose  : Self-checking bench: directed vector table on the default
//            32x4 configuration, an 8x3 instance, and protocol/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nop_seq_multiplier;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_err;

  nop_seq_multiplier_if #(.WIDTH(32), .NUM_OPS(4)) bus_a ();
  nop_seq_multiplier_if #(.WIDTH(8),  .NUM_OPS(3)) bus_b ();

  nop_seq_multiplier #(.WIDTH(32), .NUM_OPS(4)) u_dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  nop_seq_multiplier #(.WIDTH(8), .NUM_OPS(3)) u_dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic         sgn;
    logic [127:0] data;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full transaction on the 32x4 instance; ack raised ack_dly cycles after oDone
  task automatic op_a(input string nm, input logic sgn, input logic [127:0] data,
                      input int ack_dly, input logic [127:0] exp, input int exp_lat);
    int lat;
    @(negedge Clock);
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = data;
    bus_a.iSigned     = sgn;
    @(negedge Clock);
    bus_a.iValid_Data = 1'b0;
    chk({nm, " idle_drop"}, 128'(bus_a.oIdle), 128'd0);
    lat = 0;
    while (!bus_a.oDone && lat < 300) begin
      @(negedge Clock);
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, " result"}, bus_a.oResult, exp);
    repeat (ack_dly) @(negedge Clock);
    chk({nm, " done_held"}, 128'(bus_a.oDone), 128'd1);
    bus_a.iAcknoledged = 1'b1;
    @(negedge Clock);
    chk({nm, " done_clear"}, 128'(bus_a.oDone), 128'd0);
    bus_a.iAcknoledged = 1'b0;
    @(negedge Clock);
    chk({nm, " idle_back"}, 128'(bus_a.oIdle), 128'd1);
  endtask

  // Transaction on the 8x3 instance
  task automatic op_b(input string nm, input logic sgn, input logic [23:0] data,
                      input logic [23:0] exp, input int exp_lat);
    int lat;
    @(negedge Clock);
    bus_b.iValid_Data = 1'b1;
    bus_b.iData       = data;
    bus_b.iSigned     = sgn;
    @(negedge Clock);
    bus_b.iValid_Data = 1'b0;
    lat = 0;
    while (!bus_b.oDone && lat < 300) begin
      @(negedge Clock);
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, " result"}, 128'(bus_b.oResult), 128'(exp));
    bus_b.iAcknoledged = 1'b1;
    @(negedge Clock);
    bus_b.iAcknoledged = 1'b0;
    @(negedge Clock);
    chk({nm, " idle_back"}, 128'(bus_b.oIdle), 128'd1);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_err    = 0;

    vecs[0] = '{1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd24, 97};
    vecs[1] = '{1'b1, {32'd4, 32'd3, 32'd2, 32'hFFFFFFFF},
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFE8, 97};
    vecs[2] = '{1'b1, {32'd4, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF}, 128'd24, 97};
    vecs[3] = '{1'b1, {32'd1, 32'd1, 32'd1, 32'h80000000},
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_80000000, 97};
    vecs[4] = '{1'b0, {4{32'hFFFFFFFF}},
                128'hFFFFFFFC_00000005_FFFFFFFC_00000001, 97};
    vecs[5] = '{1'b0, {32'd7, 32'd6, 32'd5, 32'd0}, 128'd0, 1};
    vecs[6] = '{1'b1, {32'd9, 32'd7, 32'd0, 32'hFFFFFFFD}, 128'd0, 1};
    vecs[7] = '{1'b1, {4{32'h80000000}},
                128'h10000000_00000000_00000000_00000000, 97};
    vecs[8] = '{1'b1, {32'd1, 32'h80000000, 32'h80000000, 32'h80000000},
                128'hFFFFFFFF_E0000000_00000000_00000000, 97};
    vecs[9] = '{1'b0, {4{32'h00010000}},
                128'h00000000_00000001_00000000_00000000, 97};

    Reset              = 1'b0;
    bus_a.iValid_Data  = 1'b0;
    bus_a.iData        = '0;
    bus_a.iSigned      = 1'b0;
    bus_a.iAcknoledged = 1'b0;
    bus_b.iValid_Data  = 1'b0;
    bus_b.iData        = '0;
    bus_b.iSigned      = 1'b0;
    bus_b.iAcknoledged = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset idle",   128'(bus_a.oIdle), 128'd1);
    chk("reset done",   128'(bus_a.oDone), 128'd0);
    chk("reset result", bus_a.oResult,     128'd0);
    Reset = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 10; i++)
      op_a($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].data,
           (i == 0) ? 5 : 1, vecs[i].exp, vecs[i].lat);

    op_b("w8 max",  1'b0, {8'd255, 8'd255, 8'd255}, 24'hFD02FF, 17);
    op_b("w8 neg",  1'b1, {8'h80, 8'h80, 8'h80},    24'hE00000, 17);
    op_b("w8 zero", 1'b0, {8'd2, 8'd1, 8'd0},       24'h000000, 1);

    // Valid pulses with fresh operands during MUL and DONE are ignored
    @(negedge Clock);
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = {32'd4, 32'd3, 32'd2, 32'd1};
    bus_a.iSigned     = 1'b0;
    @(negedge Clock);
    bus_a.iValid_Data = 1'b0;
    lat = 0;
    repeat (10) begin
      @(negedge Clock);
      lat++;
    end
    chk("retain during mul", bus_a.oResult, 128'h00000000_00000001_00000000_00000000);
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = {4{32'd5}};
    @(negedge Clock);
    lat++;
    bus_a.iValid_Data = 1'b0;
    while (!bus_a.oDone && lat < 300) begin
      @(negedge Clock);
      lat++;
    end
    chk("ignore latency", 128'(lat), 128'd97);
    chk("ignore mul",     bus_a.oResult, 128'd24);
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = {4{32'd7}};
    @(negedge Clock);
    bus_a.iValid_Data = 1'b0;
    chk("ignore done flag",   128'(bus_a.oDone), 128'd1);
    chk("ignore done result", bus_a.oResult,     128'd24);
    bus_a.iAcknoledged = 1'b1;
    @(negedge Clock);
    bus_a.iAcknoledged = 1'b0;
    @(negedge Clock);
    chk("retain in idle", bus_a.oResult, 128'd24);

    // Reset in the middle of MUL discards the computation
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = {32'd4, 32'd3, 32'd2, 32'd1};
    @(negedge Clock);
    bus_a.iValid_Data = 1'b0;
    repeat (20) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midreset idle",   128'(bus_a.oIdle), 128'd1);
    chk("midreset done",   128'(bus_a.oDone), 128'd0);
    chk("midreset result", bus_a.oResult,     128'd0);
    Reset = 1'b1;
    op_a("after reset", 1'b0, {32'd5, 32'd4, 32'd3, 32'd2}, 1, 128'd120, 97);

    // Acknowledge already high when oDone rises: one-cycle oDone, then wait
    bus_a.iAcknoledged = 1'b1;
    @(negedge Clock);
    bus_a.iValid_Data = 1'b1;
    bus_a.iData       = {32'd3, 32'd1, 32'd1, 32'd1};
    @(negedge Clock);
    bus_a.iValid_Data = 1'b0;
    lat = 0;
    while (!bus_a.oDone && lat < 300) begin
      @(negedge Clock);
      lat++;
    end
    chk("early ack latency", 128'(lat), 128'd97);
    chk("early ack result",  bus_a.oResult, 128'd3);
    @(negedge Clock);
    chk("early ack done pulse", 128'(bus_a.oDone), 128'd0);
    repeat (3) @(negedge Clock);
    chk("early ack waiting", 128'(bus_a.oIdle), 128'd0);
    bus_a.iAcknoledged = 1'b0;
    @(negedge Clock);
    chk("early ack idle", 128'(bus_a.oIdle), 128'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
